bg_scaler_stream: RTL and testbench

- Parametrised background renderer: maps the VGA raster position (DrawX, DrawY) to a source-image pixel.
- Reads the colour index from an external synchronous ROM, resolves it through an external palette, and drives registered 4-bit RGB.
- Replaces per-pixel multiply/divide stretching with fixed-point step accumulators.
- Adds a scroll/tile mode and a configurable ROM read latency.
- Sits between the VGA controller and the colour mapper, in the vga_clk domain.

---
 rtl/bg_scaler_stream.sv | 117 +++++++++++
 tb/tb_bg_scaler_stream.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_scaler_stream.sv
// Background scaler: maps the raster position to a source-image pixel with
// fixed-point step accumulators, fetches its palette index and registers RGB.
module bg_scaler_stream #(
  parameter int SRC_W   = 2388,
  parameter int SRC_H   = 1668,
  parameter int DST_W   = 640,
  parameter int DST_H   = 480,
  parameter int FRAC    = 16,
  parameter int IDX_W   = 4,
  parameter int ROM_LAT = 1,
  parameter int ADDR_W  = 22
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              mode,
  input  logic [11:0]       scroll_x,
  input  logic [11:0]       scroll_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);
  localparam int ACC_W = FRAC + 12;
  localparam logic [ACC_W-1:0] STEP_X = ACC_W'((64'(SRC_W) << FRAC) / 64'(DST_W));
  localparam logic [ACC_W-1:0] STEP_Y = ACC_W'((64'(SRC_H) << FRAC) / 64'(DST_H));
  localparam logic [ACC_W-1:0] STEP_1 = ACC_W'(64'(1) << FRAC);
  localparam logic [ACC_W-1:0] WRAP_X = ACC_W'(64'(SRC_W) << FRAC);
  localparam logic [ACC_W-1:0] WRAP_Y = ACC_W'(64'(SRC_H) << FRAC);
  localparam logic [11:0] SRC_W12 = 12'(SRC_W);
  localparam logic [11:0] SRC_H12 = 12'(SRC_H);
  localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);

  logic [9:0]        prev_x_q, prev_y_q;
  logic              mode_q;
  logic [11:0]       sx_q, sy_q;
  logic [ACC_W-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0]  blank_sr_q;
  logic [11:0]       rgb_q, rgb_d;

  logic              frame_start, mode_eff;
  logic [11:0]       sx_eff, sy_eff;
  logic [ACC_W-1:0]  step_x, step_y, sum_x, sum_y;
  logic [11:0]       x_raw, y_raw, x_int, y_int;

  always_comb begin
    frame_start = (DrawX == 10'd0) && (DrawY == 10'd0) &&
                  ((DrawX != prev_x_q) || (DrawY != prev_y_q));
    // Controls latched at frame start already govern that first pixel.
    mode_eff = frame_start ? mode : mode_q;
    sx_eff   = sx_q;
    sy_eff   = sy_q;
    if (frame_start) begin
      sx_eff = (scroll_x >= SRC_W12) ? 12'd0 : scroll_x;
      sy_eff = (scroll_y >= SRC_H12) ? 12'd0 : scroll_y;
    end
    step_x = mode_eff ? STEP_1 : STEP_X;
    step_y = mode_eff ? STEP_1 : STEP_Y;

    if (DrawX == 10'd0)         sum_x = mode_eff ? {sx_eff, {FRAC{1'b0}}} : '0;
    else if (DrawX != prev_x_q) sum_x = acc_x_q + step_x;
    else                        sum_x = acc_x_q;

    if (DrawY == 10'd0)         sum_y = mode_eff ? {sy_eff, {FRAC{1'b0}}} : '0;
    else if (DrawY != prev_y_q) sum_y = acc_y_q + step_y;
    else                        sum_y = acc_y_q;

    acc_x_d = (mode_eff && (sum_x >= WRAP_X)) ? sum_x - WRAP_X : sum_x;
    acc_y_d = (mode_eff && (sum_y >= WRAP_Y)) ? sum_y - WRAP_Y : sum_y;

    x_raw = acc_x_d[ACC_W-1:FRAC];
    y_raw = acc_y_d[ACC_W-1:FRAC];
    x_int = (!mode_eff && (x_raw >= SRC_W12)) ? SRC_W12 - 12'd1 : x_raw;
    y_int = (!mode_eff && (y_raw >= SRC_H12)) ? SRC_H12 - 12'd1 : y_raw;

    rom_addr_d = ADDR_W'(y_int) * SRC_W_A + ADDR_W'(x_int);
    rgb_d      = blank_sr_q[ROM_LAT] ? {pal_red, pal_green, pal_blue} : 12'h000;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      mode_q     <= 1'b0;
      sx_q       <= '0;
      sy_q       <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      rom_addr_q <= '0;
      blank_sr_q <= '0;
      rgb_q      <= '0;
    end else begin
      prev_x_q   <= DrawX;
      prev_y_q   <= DrawY;
      mode_q     <= mode_eff;
      sx_q       <= sx_eff;
      sy_q       <= sy_eff;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      rom_addr_q <= rom_addr_d;
      blank_sr_q <= {blank_sr_q[ROM_LAT-1:0], blank};
      rgb_q      <= rgb_d;
    end
  end

  assign rom_addr           = rom_addr_q;
  assign pal_index          = rom_q;
  assign {red, green, blue} = rgb_q;
endmodule

// File: tb/tb_bg_scaler_stream.sv
// Bench for bg_scaler_stream: two instances (ROM latency 1 and 3) walked over
// partial frames with random blank/stalls, compared against a position model.
module tb_bg_scaler_stream;
  localparam int SRC_W = 2388, SRC_H = 1668, DST_W = 640, DST_H = 480;
  localparam int FRAC = 16, ADDR_W = 22;
  localparam longint STEP_X = (longint'(SRC_W) << FRAC) / DST_W;
  localparam longint STEP_Y = (longint'(SRC_H) << FRAC) / DST_H;

  logic vga_clk = 1'b0, reset_n = 1'b0, blank = 1'b0, mode = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic [11:0] scroll_x = '0, scroll_y = '0;
  logic [ADDR_W-1:0] rom_addr1, rom_addr3;
  logic [3:0] rom_q1, rom_q3, pal_index1, pal_index3;
  logic [3:0] pal_r1, pal_g1, pal_b1, pal_r3, pal_g3, pal_b3;
  logic [3:0] red1, green1, blue1, red3, green3, blue3;
  logic [3:0] p1, p3a, p3b, p3c;

  int n_checks = 0, n_errors = 0;

  always #5 vga_clk = ~vga_clk;

  bg_scaler_stream #(.ROM_LAT(1)) dut1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .mode(mode), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .rom_addr(rom_addr1), .rom_q(rom_q1), .pal_index(pal_index1),
    .pal_red(pal_r1), .pal_green(pal_g1), .pal_blue(pal_b1),
    .red(red1), .green(green1), .blue(blue1));

  bg_scaler_stream #(.ROM_LAT(3)) dut3 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .mode(mode), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .rom_addr(rom_addr3), .rom_q(rom_q3), .pal_index(pal_index3),
    .pal_red(pal_r3), .pal_green(pal_g3), .pal_blue(pal_b3),
    .red(red3), .green(green3), .blue(blue3));

  // ROMs return the low address nibble after their latency; palettes are fixed maps.
  always @(posedge vga_clk) begin
    p1  <= rom_addr1[3:0];
    p3a <= rom_addr3[3:0];
    p3b <= p3a;
    p3c <= p3b;
  end
  assign rom_q1 = p1;
  assign rom_q3 = p3c;
  assign pal_r1 = pal_index1;
  assign pal_g1 = ~pal_index1;
  assign pal_b1 = pal_index1 ^ 4'h5;
  assign pal_r3 = pal_index3;
  assign pal_g3 = ~pal_index3;
  assign pal_b3 = pal_index3 ^ 4'h5;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: source coordinate from the number of position changes along the line/frame.
  function automatic longint ref_addr(int nx, int ny, bit md, int sx, int sy);
    longint xi, yi;
    if (md) begin
      xi = (sx + nx) % SRC_W;
      yi = (sy + ny) % SRC_H;
    end else begin
      xi = (longint'(nx) * STEP_X) >> FRAC;
      yi = (longint'(ny) * STEP_Y) >> FRAC;
      if (xi > SRC_W - 1) xi = SRC_W - 1;
      if (yi > SRC_H - 1) yi = SRC_H - 1;
    end
    return (yi * SRC_W + xi) % (longint'(1) << ADDR_W);
  endfunction

  int unsigned cyc = 0;
  int sr = 0, m_nx = 0, m_ny = 0, m_sx = 0, m_sy = 0;
  bit m_mode = 1'b0;
  logic [9:0] m_px = '0, m_py = '0;
  longint h_addr [8];
  bit h_blank [8];

  always @(posedge vga_clk) begin
    cyc++;
    if (!reset_n) begin
      m_px = '0; m_py = '0; m_nx = 0; m_ny = 0;
      m_mode = 1'b0; m_sx = 0; m_sy = 0; sr = 0;
    end else begin
      if (DrawX == 0 && DrawY == 0 && (m_px != 0 || m_py != 0)) begin
        m_mode = mode;
        m_sx = (int'(scroll_x) < SRC_W) ? int'(scroll_x) : 0;
        m_sy = (int'(scroll_y) < SRC_H) ? int'(scroll_y) : 0;
      end
      if (DrawX == 0) m_nx = 0; else if (DrawX != m_px) m_nx++;
      if (DrawY == 0) m_ny = 0; else if (DrawY != m_py) m_ny++;
      m_px = DrawX;
      m_py = DrawY;
      h_addr[cyc % 8]  = ref_addr(m_nx, m_ny, m_mode, m_sx, m_sy);
      h_blank[cyc % 8] = blank;
      sr++;
    end
  end

  function automatic logic [11:0] ref_rgb(int unsigned k);
    logic [3:0] idx;
    idx = 4'(h_addr[k % 8] % 16);
    return h_blank[k % 8] ? {idx, ~idx, idx ^ 4'h5} : 12'h000;
  endfunction

  always @(negedge vga_clk) begin
    if (reset_n && sr >= 1) begin
      chk("rom_addr_lat1", rom_addr1, h_addr[cyc % 8]);
      chk("rom_addr_lat3", rom_addr3, h_addr[cyc % 8]);
    end
    if (reset_n && sr >= 3) chk("rgb_lat1", {red1, green1, blue1}, ref_rgb(cyc - 2));
    if (reset_n && sr >= 5) chk("rgb_lat3", {red3, green3, blue3}, ref_rgb(cyc - 4));
  end

  typedef struct { int x; int y; longint ex; } probe_t;
  probe_t probes[$];
  int full_rows[$];
  int xfull = 639, rst_x = -1, rst_y = -1;
  bit mid_en = 1'b0, mid_mode = 1'b0;
  logic [11:0] mid_sx = '0, mid_sy = '0;

  task automatic add_probe(input int x, input int y, input longint ex);
    probe_t p;
    p.x = x; p.y = y; p.ex = ex;
    probes.push_back(p);
  endtask

  task automatic async_reset();
    @(negedge vga_clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_addr1", rom_addr1, 0);
    chk("async_rst_addr3", rom_addr3, 0);
    chk("async_rst_rgb1", {red1, green1, blue1}, 0);
    chk("async_rst_rgb3", {red3, green3, blue3}, 0);
    @(posedge vga_clk);
    @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  task automatic pix(input int x, input int y);
    @(negedge vga_clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = ($urandom_range(0, 7) != 0);
    if ($urandom_range(0, 9) == 0)
      repeat ($urandom_range(1, 2)) begin
        @(negedge vga_clk);
        blank = ($urandom_range(0, 3) != 0);
      end
  endtask

  task automatic step(input int x, input int y);
    pix(x, y);
    if (x == rst_x && y == rst_y) async_reset();
    foreach (probes[i])
      if (probes[i].x == x && probes[i].y == y) begin
        @(posedge vga_clk);
        #1;
        chk($sformatf("addr_at_%0d_%0d", x, y), rom_addr1, probes[i].ex);
      end
  endtask

  task automatic run_frame(input int ymax);
    for (int y = 0; y <= ymax; y++) begin
      bit full;
      int n;
      full = 1'b0;
      foreach (full_rows[i]) if (full_rows[i] == y) full = 1'b1;
      n = full ? xfull : int'($urandom_range(0, 2));
      for (int x = 0; x <= n; x++) step(x, y);
      if (mid_en && y == 200) begin
        mode = mid_mode;
        scroll_x = mid_sx;
        scroll_y = mid_sy;
      end
    end
  endtask

  task automatic new_frame_cfg();
    probes.delete();
    full_rows.delete();
    mid_en = 1'b0;
    xfull = 639;
  endtask

  initial begin
    int sy;
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_addr1", rom_addr1, 0);
    chk("rst_addr3", rom_addr3, 0);
    chk("rst_rgb1", {red1, green1, blue1}, 0);
    chk("rst_rgb3", {red3, green3, blue3}, 0);
    @(negedge vga_clk);
    reset_n = 1'b1;

    // Stretch from reset defaults
    new_frame_cfg();
    full_rows.push_back(0); full_rows.push_back(479);
    add_probe(0, 0, 0);
    add_probe(639, 479, 3976016);
    run_frame(479);

    // Scroll 2000/1600 with a mid-frame switch back to stretch
    new_frame_cfg();
    mode = 1'b1; scroll_x = 12'd2000; scroll_y = 12'd1600;
    full_rows.push_back(67); full_rows.push_back(68);
    full_rows.push_back(200); full_rows.push_back(250);
    add_probe(388, 67, 3980796);
    add_probe(387, 67, 3983183);
    add_probe(400, 68, 12);
    add_probe(10, 250, 436626);
    mid_en = 1'b1; mid_mode = 1'b0;
    mid_sx = 12'($urandom_range(0, 4095)); mid_sy = 12'($urandom_range(0, 4095));
    run_frame(479);

    // Stretch over the full 10-bit raster to reach the clamps
    new_frame_cfg();
    xfull = 1023;
    full_rows.push_back(0); full_rows.push_back(479); full_rows.push_back(1023);
    add_probe(0, 0, 0);
    add_probe(639, 479, 3976016);
    add_probe(1023, 479, 3976019);
    add_probe(1023, 1023, 3983183);
    run_frame(1023);

    // Random mode and offsets, with a random mid-frame change
    new_frame_cfg();
    mode = 1'($urandom_range(0, 1));
    scroll_x = 12'($urandom_range(0, 4095)); scroll_y = 12'($urandom_range(0, 4095));
    repeat (3) full_rows.push_back($urandom_range(1, 479));
    mid_en = 1'b1; mid_mode = 1'($urandom_range(0, 1));
    mid_sx = 12'($urandom_range(0, 4095)); mid_sy = 12'($urandom_range(0, 4095));
    run_frame(479);

    // Scroll with an out-of-range horizontal offset
    new_frame_cfg();
    sy = $urandom_range(0, SRC_H - 1);
    mode = 1'b1;
    scroll_x = 12'($urandom_range(SRC_W, 4095)); scroll_y = 12'(sy);
    repeat (3) full_rows.push_back($urandom_range(1, 479));
    add_probe(0, 0, longint'(sy) * SRC_W);
    run_frame(479);

    // Stretch with an asynchronous reset in the middle of a line
    new_frame_cfg();
    mode = 1'b0;
    full_rows.push_back(100); full_rows.push_back(479);
    rst_x = 300; rst_y = 100;
    run_frame(479);
    rst_x = -1; rst_y = -1;

    // Recovery frame
    new_frame_cfg();
    full_rows.push_back(0); full_rows.push_back(479);
    add_probe(0, 0, 0);
    add_probe(639, 479, 3976016);
    run_frame(479);

    repeat (8) @(negedge vga_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
